// File: rtl/instr_encoder.sv
// instr_encoder
//   Packs a decoded RV32I micro-op (opcode, rd/rs1/rs2, funct3/funct7 and a
//   32-bit immediate) back into a 32-bit instruction word. Encoded results are
//   queued in a small output FIFO with valid/ready handshakes on both sides.
//
// Parameters
//   DEPTH      output FIFO entries (power of two, >= 2)
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst_n      asynchronous active-low reset (FIFO emptied, RAM untouched)
//   flush      synchronous clear of FIFO contents, beats push and pop
//   in_valid   micro-op present            in_ready   encoder can accept (!full)
//   in_opcode  RISC-V opcode               in_rd/in_rs1/in_rs2  register indices
//   in_funct3  funct3                      in_funct7  funct7 (R-type only)
//   in_imm     immediate as produced by the immediate decoder
//   out_valid  FIFO non-empty              out_ready  consumer accepts
//   out_instr  encoded word at FIFO head   out_err    head had unknown opcode /
//                                                     out-of-range immediate
//
// Build option
//   ENC_RANGE_CHECK_EN  when defined, immediates that do not fit their format
//                       also raise err (the word is still built from the
//                       truncated bits). When undefined only unknown opcodes
//                       raise err.

module instr_encoder #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  in_opcode,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [6:0] {
    OP_IMM    = 7'b0010011,
    OP_JALR   = 7'b1100111,
    OP_LOAD   = 7'b0000011,
    OP_LUI    = 7'b0110111,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011,
    OP_REG    = 7'b0110011
  } opcode_e;

  typedef struct packed {
    logic        err;
    logic [31:0] instr;
  } entry_t;

  // ---------------------------------------------------------------------------
  // Encoder (purely combinational on the inputs)
  // ---------------------------------------------------------------------------
`ifdef ENC_RANGE_CHECK_EN
  // An immediate fits a signed field when all bits above it match its sign bit.
  logic fits_12;
  logic fits_b;
  logic fits_u;
  assign fits_12 = (&in_imm[31:11]) | ~(|in_imm[31:11]);
  assign fits_b  = ~in_imm[0] & ((&in_imm[31:12]) | ~(|in_imm[31:12]));
  assign fits_u  = ~(|in_imm[11:0]);
`endif

  entry_t enc;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    enc.instr = NOP_WORD;
    enc.err   = 1'b1;
    case (in_opcode)
      OP_IMM, OP_JALR, OP_LOAD: begin
        enc.instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
`ifdef ENC_RANGE_CHECK_EN
        enc.err   = ~fits_12;
`else
        enc.err   = 1'b0;
`endif
      end
      OP_LUI: begin
        enc.instr = {in_imm[31:12], in_rd, in_opcode};
`ifdef ENC_RANGE_CHECK_EN
        enc.err   = ~fits_u;
`else
        enc.err   = 1'b0;
`endif
      end
      OP_STORE: begin
        enc.instr = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
`ifdef ENC_RANGE_CHECK_EN
        enc.err   = ~fits_12;
`else
        enc.err   = 1'b0;
`endif
      end
      OP_BRANCH: begin
        // Branch offsets are scrambled so that the sign bit stays at [31].
        enc.instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                     in_imm[4:1], in_imm[11], in_opcode};
`ifdef ENC_RANGE_CHECK_EN
        enc.err   = ~fits_b;
`else
        enc.err   = 1'b0;
`endif
      end
      OP_REG: begin
        enc.instr = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
        enc.err   = 1'b0;
      end
      default: begin
        enc.instr = NOP_WORD;
        enc.err   = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output FIFO
  // ---------------------------------------------------------------------------
  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  entry_t          last_q, last_d;   // last popped entry, shown while empty
  entry_t          head;
  logic            push;
  logic            pop;

  assign in_ready  = (count_q != FULL_CNT);
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;
  assign head      = mem_q[rd_ptr_q];

  assign out_instr = out_valid ? head.instr : last_q.instr;
  assign out_err   = out_valid ? head.err   : last_q.err;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    last_d   = last_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap by plain overflow.
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
        last_d   = head;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + (AW + 1)'(1);
        2'b01:   count_d = count_q - (AW + 1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every register samples the pre-edge values of its peers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      last_q   <= last_d;
    end
  end

  // NOTE: the storage array has no reset; entries are only ever read after
  // being written, and leaving it unreset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= enc;
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed micro-ops with hand-computed
// words, a scoreboard queue filled by the driver and drained by a monitor.

module tb_instr_encoder;

  localparam int DEPTH = 2;

`ifdef ENC_RANGE_CHECK_EN
  localparam logic RC = 1'b1;
`else
  localparam logic RC = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;

  instr_encoder #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_opcode (in_opcode),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_funct3 (in_funct3),
    .in_funct7 (in_funct7),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_err   (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        err;
    logic [31:0] instr;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_out = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] decode_b(input logic [31:0] w);
    return {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
  endfunction

  // Monitor: a transfer happens at the next rising edge when valid&&ready is
  // seen here on the falling edge (inputs only change just after rising edges).
  always @(negedge clk) begin
    if (rst_n && !flush && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_output: got %0h expected no output", out_instr);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_instr", {32'h0, out_instr}, {32'h0, e.instr});
        check("out_err", {63'h0, out_err}, {63'h0, e.err});
        last_out = out_instr;
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] imm, input logic [31:0] exp_instr, input logic exp_err);
    bit done;
    done      = 1'b0;
    in_opcode = op;
    in_rd     = rd;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_funct3 = f3;
    in_funct7 = f7;
    in_imm    = imm;
    in_valid  = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back('{err: exp_err, instr: exp_instr});
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 expected accept of %0h", exp_instr);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    check("drained", 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_funct3 = '0; in_funct7 = '0; in_imm = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", {63'h0, out_valid}, 64'd0);
    check("rst_in_ready", {63'h0, in_ready}, 64'd1);
    check("rst_out_instr", {32'h0, out_instr}, 64'd0);
    check("rst_out_err", {63'h0, out_err}, 64'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;

    // addi x1, x0, 5 with junk rs2/funct7 that must not leak into the word.
    send(7'b0010011, 5'd1, 5'd0, 5'd31, 3'd0, 7'h7F, 32'd5, 32'h0050_0093, 1'b0);
    @(negedge clk);
    check("latency_valid", {63'h0, out_valid}, 64'd1);
    @(posedge clk); #1;

    send(7'b0110111, 5'd5, 5'd31, 5'd31, 3'd7, 7'h7F, 32'h1234_5000, 32'h1234_52B7, 1'b0);
    send(7'b0100011, 5'd31, 5'd1, 5'd2, 3'd2, 7'h7F, 32'd8, 32'h0020_A423, 1'b0);
    send(7'b1100011, 5'd31, 5'd1, 5'd2, 3'd1, 7'h7F, 32'hFFFF_FFFC, 32'hFE20_9EE3, 1'b0);
    drain();
    check("bne_roundtrip", {32'h0, decode_b(last_out)}, {32'h0, 32'hFFFF_FFFC});

    send(7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'hFFFF_FFFF, 32'h4020_81B3, 1'b0);
    send(7'b0000011, 5'd6, 5'd2, 5'd31, 3'd2, 7'h7F, 32'hFFFF_FFFF, 32'hFFF1_2303, 1'b0);
    send(7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_0002, 32'h0000_0163, 1'b0);
    send(7'b0010011, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_0800, 32'h8000_0013, RC);
    send(7'b0110111, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_0FFF, 32'h0000_0037, RC);
    send(7'b1111111, 5'd3, 5'd4, 5'd5, 3'd6, 7'h11, 32'h1234_5678, 32'h0000_0013, 1'b1);
    drain();

    // Backpressure: two accepts fill the FIFO, the third waits for a pop.
    out_ready = 1'b0;
    send(7'b0010011, 5'd7, 5'd3, 5'd0, 3'd0, 7'h00, 32'h0000_07FF, 32'h7FF1_8393, 1'b0);
    send(7'b1100111, 5'd1, 5'd5, 5'd0, 3'd0, 7'h00, 32'hFFFF_F800, 32'h8002_80E7, 1'b0);
    @(negedge clk);
    check("full_in_ready", {63'h0, in_ready}, 64'd0);
    check("full_out_valid", {63'h0, out_valid}, 64'd1);
    @(posedge clk); #1;
    fork
      send(7'b0100011, 5'd0, 5'd2, 5'd9, 3'd2, 7'h00, 32'hFFFF_FFE0, 32'hFE91_2023, 1'b0);
      begin
        repeat (3) @(negedge clk);
        check("held_in_ready", {63'h0, in_ready}, 64'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Asynchronous reset mid-stream.
    out_ready = 1'b0;
    send(7'b0010011, 5'd1, 5'd1, 5'd0, 3'd0, 7'h00, 32'd1, 32'h0010_8093, 1'b0);
    send(7'b0010011, 5'd2, 5'd2, 5'd0, 3'd0, 7'h00, 32'd2, 32'h0021_0113, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", {63'h0, out_valid}, 64'd0);
    check("arst_in_ready", {63'h0, in_ready}, 64'd1);
    check("arst_out_instr", {32'h0, out_instr}, 64'd0);
    sb.delete();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Flush while full with a concurrent push attempt.
    send(7'b0010011, 5'd1, 5'd1, 5'd0, 3'd0, 7'h00, 32'd1, 32'h0010_8093, 1'b0);
    send(7'b0010011, 5'd2, 5'd2, 5'd0, 3'd0, 7'h00, 32'd2, 32'h0021_0113, 1'b0);
    flush = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    check("flush_full_valid", {63'h0, out_valid}, 64'd0);
    check("flush_full_ready", {63'h0, in_ready}, 64'd1);
    @(posedge clk); #1;

    // Flush with room: the concurrent push must be dropped.
    send(7'b0010011, 5'd3, 5'd3, 5'd0, 3'd0, 7'h00, 32'd3, 32'h0031_8193, 1'b0);
    flush = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    check("flush_drop_valid", {63'h0, out_valid}, 64'd0);
    @(posedge clk); #1;

    // FIFO still works after flush.
    out_ready = 1'b1;
    send(7'b0110111, 5'd10, 5'd0, 5'd0, 3'd0, 7'h00, 32'hABCD_E000, 32'hABCD_E537, 1'b0);
    send(7'b0110011, 5'd4, 5'd5, 5'd6, 3'd7, 7'h00, 32'd0, 32'h0062_F233, 1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Packs a decoded micro-op (opcode, register fields, funct fields, 32-bit immediate) back into a 32-bit RV32I instruction word. It is the inverse of the core's immediate decoder. It sits between the test and trace infrastructure (self-modifying and replay streams) and instruction memory. Results are buffered in a small output FIFO with valid/ready handshakes on both sides. For every supported format and every in-range immediate, the immediate decoder recovers the original immediate from the produced word.

## Interface
- DEPTH, 2, output FIFO entries; power of two, ≥2
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous clear of FIFO contents
- in_valid  in  1  micro-op present
- in_ready  out  1  encoder can accept; equals !full
- in_opcode  in  7  RISC-V opcode
- in_rd / in_rs1 / in_rs2  in  5 each  register indices
- in_funct3  in  3  funct3
- in_funct7  in  7  funct7 (R-type only)
- in_imm  in  32  immediate value, as produced by the decoder
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts
- out_instr  out  32  encoded instruction at FIFO head
- out_err  out  1  head entry had an unknown opcode or an out-of-range immediate

## Operation
- Transfer occurs on valid&&ready at a rising edge, on each side independently.
- The encode step is combinational on the inputs. The result {instr, err} is written to the FIFO tail on an input transfer.
- Supported formats:
  - I (0010011, 1100111, 0000011): imm[11:0] is placed at [31:20].
  - U (0110111): imm[31:12] is placed at [31:12].
  - S (0100011): imm[11:5] is placed at [31:25], imm[4:0] at [11:7].
  - B (1100011): imm[12] at [31], imm[10:5] at [30:25], imm[4:1] at [11:8], imm[11] at [7].
  - R (0110011): funct7 is placed at [31:25].
- Fields not used by a format are driven 0 (for example, rs2 for I-type, rd for S/B-type).
- Unknown opcode: the encoded word is 32'h00000013 (NOP) and err=1.
- FIFO behaviour:
  - Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - count is log2(DEPTH)+1 bits.
  - Push and pop in the same cycle leave count unchanged.
  - When full, in_ready=0, so no push occurs. A same-cycle pop does not open a slot until the next cycle.
  - When empty, out_valid=0. out_instr and out_err hold the last popped value; they are don't-care to consumers.
- flush zeroes the pointers and count and drops any input transfer in the same cycle. flush takes priority over push and pop.
- Reset, whether mid-transfer or mid-drain, discards all entries. It does not clear the storage RAM.

## Timing
- Reset values: out_valid=0, in_ready=1, out_instr=0, out_err=0, count=0.
- Latency: an input accepted at edge N appears at out_valid at edge N when the FIFO is empty, i.e. visible in cycle N+1. There is no combinational path from input to output.
- Throughput: one instruction per cycle when out_ready is held high.
- in_ready depends only on registered count. It has no combinational path from out_ready.
- out_instr and out_err are stable while out_valid=1 and out_ready=0.

## Configuration
- ENC_RANGE_CHECK_EN defined:
  - err=1 when the immediate does not fit its format:
    - I/S: in_imm[31:11] not all equal.
    - B: in_imm[0]≠0 or in_imm[31:12] not all equal.
    - U: in_imm[11:0]≠0.
  - On a range error the word is still encoded from the truncated bits.
- ENC_RANGE_CHECK_EN undefined: range checks are removed, and err is set only for unknown opcodes.

## Test plan
- addi: opcode 0010011, rd=1, rs1=0, f3=0, imm=5 -> out_instr=0x00500093, err=0, one cycle after accept.
- LUI: opcode 0110111, rd=5, imm=0x12345000 -> 0x123452B7. sw: opcode 0100011, rs1=1, rs2=2, f3=2, imm=8 -> 0x0020A423.
- bne: opcode 1100011, rs1=1, rs2=2, f3=1, imm=0xFFFFFFFC -> 0xFE209EE3. Feeding the result into the immediate decoder returns 0xFFFFFFFC.
- Range check (macro on): addi with imm=0x800 -> err=1, instr=0x80000013. Opcode 1111111 -> 0x00000013, err=1 in both builds.
- Backpressure: out_ready=0 with 3 pushes at DEPTH=2 -> in_ready falls after 2 accepts. The third op is held until the first pop. Order is preserved.
- Reset and flush: assert rst_n=0 mid-stream -> out_valid=0 and in_ready=1 immediately. flush with count=2 and a concurrent push -> count=0 next cycle.
